// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3/funct7 codes, ALU operation set.
package rv32i_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    // Map funct3 plus the funct7[5] "alternate" bit onto an ALU operation.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 integer register file: two combinational reads, one write, x0 reads zero.
module rv32i_regfile
    import rv32i_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_rs1_raddr,
    input  logic [REG_AW-1:0] i_rs2_raddr,
    output logic [XLEN-1:0]   o_rs1_rdata,
    output logic [XLEN-1:0]   o_rs2_rdata,
    input  logic              i_wen,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else if (i_wen && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rs1_rdata = (i_rs1_raddr == '0) ? '0 : r_regs[i_rs1_raddr];
    assign o_rs2_rdata = (i_rs2_raddr == '0) ? '0 : r_regs[i_rs2_raddr];

endmodule

// File: rtl/rv32i_hart.sv
// Single-cycle RV32I hart: fetch, decode, execute, memory and writeback in one clock,
// with a combinational retire port describing the instruction committed this cycle.
module rv32i_hart
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [XLEN-1:0]   o_imem_raddr,
    input  logic [XLEN-1:0]   i_imem_rdata,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic              o_dmem_ren,
    output logic              o_dmem_wen,
    output logic [XLEN-1:0]   o_dmem_wdata,
    output logic [3:0]        o_dmem_mask,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic              o_retire_valid,
    output logic [XLEN-1:0]   o_retire_inst,
    output logic              o_retire_trap,
    output logic              o_retire_halt,
    output logic [REG_AW-1:0] o_retire_rs1_raddr,
    output logic [REG_AW-1:0] o_retire_rs2_raddr,
    output logic [XLEN-1:0]   o_retire_rs1_rdata,
    output logic [XLEN-1:0]   o_retire_rs2_rdata,
    output logic [REG_AW-1:0] o_retire_rd_waddr,
    output logic [XLEN-1:0]   o_retire_rd_wdata,
    output logic [XLEN-1:0]   o_retire_pc,
    output logic [XLEN-1:0]   o_retire_next_pc
);

    logic [XLEN-1:0]   r_pc;
    logic              r_halted;

    logic [XLEN-1:0]   w_inst;
    logic [6:0]        w_opcode, w_funct7;
    logic [2:0]        w_funct3;
    logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0]   w_rs1_rdata, w_rs2_rdata;
    logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic              w_illegal, w_rd_we, w_is_load, w_is_store, w_is_branch, w_is_jump, w_is_ebreak;
    alu_op_e           w_alu_op;
    logic [XLEN-1:0]   w_alu_a, w_alu_b, w_alu_res;
    logic              w_br_cond, w_taken, w_valid, w_trap, w_commit, w_rd_write;
    logic [XLEN-1:0]   w_jalr_sum, w_target, w_pc_plus4, w_next_pc;
    logic [XLEN-1:0]   w_ea, w_store_data, w_load_lane, w_load_data, w_rd_result;
    logic [3:0]        w_mem_mask;
    logic              w_mem_misaligned, w_ren, w_wen;

    assign w_inst   = i_imem_rdata;
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_funct3 = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_funct7 = w_inst[31:25];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    rv32i_regfile u_regfile (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rs1_raddr (w_rs1),
        .i_rs2_raddr (w_rs2),
        .o_rs1_rdata (w_rs1_rdata),
        .o_rs2_rdata (w_rs2_rdata),
        .i_wen       (w_rd_write),
        .i_waddr     (w_rd),
        .i_wdata     (w_rd_result)
    );

    // Instruction class, operand selection and legality.
    always_comb begin
        w_illegal   = 1'b0;
        w_rd_we     = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_is_ebreak = 1'b0;
        w_alu_op    = ALU_ADD;
        w_alu_a     = w_rs1_rdata;
        w_alu_b     = w_rs2_rdata;
        case (w_opcode)
            OPC_LUI:    begin w_rd_we = 1'b1; w_alu_op = ALU_PASS_B; w_alu_b = w_imm_u; end
            OPC_AUIPC:  begin w_rd_we = 1'b1; w_alu_a = r_pc; w_alu_b = w_imm_u; end
            OPC_JAL:    begin w_rd_we = 1'b1; w_is_jump = 1'b1; end
            OPC_JALR:   begin w_rd_we = 1'b1; w_is_jump = 1'b1; w_illegal = (w_funct3 != 3'd0); end
            OPC_BRANCH: begin
                w_is_branch = 1'b1;
                w_illegal   = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
            end
            OPC_LOAD:   begin
                w_rd_we   = 1'b1;
                w_is_load = 1'b1;
                w_illegal = !((w_funct3 == F3_B) || (w_funct3 == F3_H) || (w_funct3 == F3_W) ||
                              (w_funct3 == F3_BU) || (w_funct3 == F3_HU));
            end
            OPC_STORE:  begin
                w_is_store = 1'b1;
                w_illegal  = !((w_funct3 == F3_B) || (w_funct3 == F3_H) || (w_funct3 == F3_W));
            end
            OPC_OP_IMM: begin
                w_rd_we  = 1'b1;
                w_alu_b  = w_imm_i;
                w_alu_op = alu_decode(w_funct3, (w_funct3 == F3_SR) && w_funct7[5]);
                if (w_funct3 == F3_SLL)
                    w_illegal = (w_funct7 != F7_BASE);
                else if (w_funct3 == F3_SR)
                    w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
            end
            OPC_OP:     begin
                w_rd_we   = 1'b1;
                w_alu_op  = alu_decode(w_funct3, w_funct7[5]);
                w_illegal = !((w_funct7 == F7_BASE) ||
                              ((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR))));
            end
            OPC_MISC_MEM: w_illegal = (w_funct3 != 3'd0);
            OPC_SYSTEM: begin
                w_is_ebreak = (w_inst == INST_EBREAK);
                w_illegal   = (w_inst != INST_EBREAK);
            end
            default:    w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALU_ADD:    w_alu_res = w_alu_a + w_alu_b;
            ALU_SUB:    w_alu_res = w_alu_a - w_alu_b;
            ALU_SLL:    w_alu_res = w_alu_a << w_alu_b[4:0];
            ALU_SLT:    w_alu_res = XLEN'($signed(w_alu_a) < $signed(w_alu_b));
            ALU_SLTU:   w_alu_res = XLEN'(w_alu_a < w_alu_b);
            ALU_XOR:    w_alu_res = w_alu_a ^ w_alu_b;
            ALU_SRL:    w_alu_res = w_alu_a >> w_alu_b[4:0];
            ALU_SRA:    w_alu_res = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
            ALU_OR:     w_alu_res = w_alu_a | w_alu_b;
            ALU_AND:    w_alu_res = w_alu_a & w_alu_b;
            ALU_PASS_B: w_alu_res = w_alu_b;
            default:    w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_br_cond = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_br_cond = (w_rs1_rdata == w_rs2_rdata);
            F3_BNE:  w_br_cond = (w_rs1_rdata != w_rs2_rdata);
            F3_BLT:  w_br_cond = ($signed(w_rs1_rdata) <  $signed(w_rs2_rdata));
            F3_BGE:  w_br_cond = ($signed(w_rs1_rdata) >= $signed(w_rs2_rdata));
            F3_BLTU: w_br_cond = (w_rs1_rdata <  w_rs2_rdata);
            F3_BGEU: w_br_cond = (w_rs1_rdata >= w_rs2_rdata);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_rs1_rdata + w_imm_i;
    assign w_target   = (w_opcode == OPC_JALR) ? (w_jalr_sum & ~XLEN'(1)) :
                        (w_opcode == OPC_JAL)  ? (r_pc + w_imm_j) : (r_pc + w_imm_b);
    assign w_taken    = w_is_jump || (w_is_branch && w_br_cond);
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_next_pc  = w_taken ? w_target : w_pc_plus4;

    // Lane selection: funct3[1:0] gives the access size for both loads and stores.
    assign w_ea = w_rs1_rdata + (w_is_store ? w_imm_s : w_imm_i);
    always_comb begin
        w_mem_mask       = 4'b0000;
        w_mem_misaligned = 1'b0;
        w_store_data     = w_rs2_rdata;
        case (w_funct3[1:0])
            2'd0: begin
                w_mem_mask   = 4'b0001 << w_ea[1:0];
                w_store_data = {4{w_rs2_rdata[7:0]}};
            end
            2'd1: begin
                w_mem_mask       = w_ea[1] ? 4'b1100 : 4'b0011;
                w_store_data     = {2{w_rs2_rdata[15:0]}};
                w_mem_misaligned = w_ea[0];
            end
            2'd2: begin
                w_mem_mask       = 4'b1111;
                w_mem_misaligned = (w_ea[1:0] != 2'b00);
            end
            default: w_mem_mask = 4'b0000;
        endcase
    end

    assign w_load_lane = i_dmem_rdata >> {w_ea[1:0], 3'b000};
    always_comb begin
        case (w_funct3)
            F3_B:    w_load_data = {{24{w_load_lane[7]}},  w_load_lane[7:0]};
            F3_H:    w_load_data = {{16{w_load_lane[15]}}, w_load_lane[15:0]};
            F3_BU:   w_load_data = {24'b0, w_load_lane[7:0]};
            F3_HU:   w_load_data = {16'b0, w_load_lane[15:0]};
            default: w_load_data = w_load_lane;
        endcase
    end

    // Reset gates validity so an in-flight store is dropped the moment rst_n falls.
    assign w_valid    = i_rst_n && !r_halted;
    assign w_trap     = w_valid && (w_illegal || (w_taken && (w_target[1:0] != 2'b00)) ||
                                    ((w_is_load || w_is_store) && w_mem_misaligned));
    assign w_commit   = w_valid && !w_trap;
    assign w_ren      = w_commit && w_is_load;
    assign w_wen      = w_commit && w_is_store;
    assign w_rd_write = w_commit && w_rd_we && (w_rd != '0);
    assign w_rd_result = w_is_load ? w_load_data : (w_is_jump ? w_pc_plus4 : w_alu_res);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_ADDR;
            r_halted <= 1'b0;
        end else if (w_valid) begin
            if (w_trap || w_is_ebreak) r_halted <= 1'b1;
            else                       r_pc     <= w_next_pc;
        end
    end

    assign o_imem_raddr       = r_pc;
    assign o_dmem_addr        = {w_ea[31:2], 2'b00};
    assign o_dmem_ren         = w_ren;
    assign o_dmem_wen         = w_wen;
    assign o_dmem_wdata       = w_store_data;
    assign o_dmem_mask        = (w_ren || w_wen) ? w_mem_mask : 4'b0000;
    assign o_retire_valid     = w_valid;
    assign o_retire_inst      = w_inst;
    assign o_retire_trap      = w_trap;
    assign o_retire_halt      = w_commit && w_is_ebreak;
    assign o_retire_rs1_raddr = w_rs1;
    assign o_retire_rs2_raddr = w_rs2;
    assign o_retire_rs1_rdata = w_rs1_rdata;
    assign o_retire_rs2_rdata = w_rs2_rdata;
    assign o_retire_rd_waddr  = w_rd_write ? w_rd : '0;
    assign o_retire_rd_wdata  = w_rd_write ? w_rd_result : '0;
    assign o_retire_pc        = r_pc;
    assign o_retire_next_pc   = w_next_pc;

endmodule

// File: tb/tb_rv32i_hart.sv
// Directed bench for rv32i_hart: instruction and load words are driven per cycle,
// and each retire/memory output is compared against hand-computed values.
module tb_rv32i_hart;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_raddr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ren, dmem_wen;
    logic [3:0]  dmem_mask;
    logic        ret_valid, ret_trap, ret_halt;
    logic [31:0] ret_inst, ret_rs1_rdata, ret_rs2_rdata, ret_rd_wdata, ret_pc, ret_next_pc;
    logic [4:0]  ret_rs1_raddr, ret_rs2_raddr, ret_rd_waddr;

    int checks   = 0;
    int failures = 0;

    rv32i_hart #(.RESET_ADDR(32'h00000000)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .o_imem_raddr       (imem_raddr),
        .i_imem_rdata       (imem_rdata),
        .o_dmem_addr        (dmem_addr),
        .o_dmem_ren         (dmem_ren),
        .o_dmem_wen         (dmem_wen),
        .o_dmem_wdata       (dmem_wdata),
        .o_dmem_mask        (dmem_mask),
        .i_dmem_rdata       (dmem_rdata),
        .o_retire_valid     (ret_valid),
        .o_retire_inst      (ret_inst),
        .o_retire_trap      (ret_trap),
        .o_retire_halt      (ret_halt),
        .o_retire_rs1_raddr (ret_rs1_raddr),
        .o_retire_rs2_raddr (ret_rs2_raddr),
        .o_retire_rs1_rdata (ret_rs1_rdata),
        .o_retire_rs2_rdata (ret_rs2_rdata),
        .o_retire_rd_waddr  (ret_rd_waddr),
        .o_retire_rd_wdata  (ret_rd_wdata),
        .o_retire_pc        (ret_pc),
        .o_retire_next_pc   (ret_next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an instruction (and load word) just after a falling edge, then let it settle.
    task automatic drive(input logic [31:0] inst, input logic [31:0] rdata);
        imem_rdata = inst;
        dmem_rdata = rdata;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'h0020A023, 32'h0);
        checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ret_valid); end
        checks++; if (dmem_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", dmem_wen); end
        checks++; if (dmem_ren !== 1'b0) begin failures++; $display("FAIL reset_ren got=%b exp=0", dmem_ren); end
        checks++; if (ret_trap !== 1'b0 || ret_halt !== 1'b0) begin failures++; $display("FAIL reset_trap_halt got=%b%b exp=00", ret_trap, ret_halt); end
        checks++; if (imem_raddr !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", imem_raddr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_addi();
        drive(32'h00500093, 32'h0);
        checks++; if (ret_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", ret_valid); end
        checks++; if (ret_pc !== 32'h0) begin failures++; $display("FAIL addi_pc got=%h exp=00000000", ret_pc); end
        checks++; if (ret_next_pc !== 32'h4) begin failures++; $display("FAIL addi_next_pc got=%h exp=00000004", ret_next_pc); end
        checks++; if (ret_rd_waddr !== 5'd1) begin failures++; $display("FAIL addi_waddr got=%0d exp=1", ret_rd_waddr); end
        checks++; if (ret_rd_wdata !== 32'h5) begin failures++; $display("FAIL addi_wdata got=%h exp=00000005", ret_rd_wdata); end
        checks++; if (dmem_ren !== 1'b0 || dmem_wen !== 1'b0 || dmem_mask !== 4'b0) begin failures++; $display("FAIL addi_nomem got=%b%b%b exp=000000", dmem_ren, dmem_wen, dmem_mask); end
        step();
    endtask

    task automatic test_setup_regs();
        drive(32'h10000093, 32'h0);
        checks++; if (ret_rd_wdata !== 32'h100) begin failures++; $display("FAIL setup_x1 got=%h exp=00000100", ret_rd_wdata); end
        step();
        drive(32'h12345137, 32'h0);
        checks++; if (ret_rd_wdata !== 32'h12345000 || ret_rd_waddr !== 5'd2) begin failures++; $display("FAIL lui_x2 got=%h/%0d exp=12345000/2", ret_rd_wdata, ret_rd_waddr); end
        step();
        drive(32'h67810113, 32'h0);
        checks++; if (ret_rs1_rdata !== 32'h12345000) begin failures++; $display("FAIL addi_x2_rs1 got=%h exp=12345000", ret_rs1_rdata); end
        checks++; if (ret_rd_wdata !== 32'h12345678) begin failures++; $display("FAIL addi_x2 got=%h exp=12345678", ret_rd_wdata); end
        step();
    endtask

    task automatic test_branch_store_jal();
        drive(32'h00000463, 32'h0);
        checks++; if (imem_raddr !== 32'h10) begin failures++; $display("FAIL beq_pc got=%h exp=00000010", imem_raddr); end
        checks++; if (ret_next_pc !== 32'h18) begin failures++; $display("FAIL beq_next_pc got=%h exp=00000018", ret_next_pc); end
        checks++; if (ret_rd_waddr !== 5'd0 || ret_rd_wdata !== 32'h0) begin failures++; $display("FAIL beq_nowrite got=%0d/%h exp=0/0", ret_rd_waddr, ret_rd_wdata); end
        step();
        drive(32'h0020A023, 32'h0);
        checks++; if (imem_raddr !== 32'h18) begin failures++; $display("FAIL sw_pc got=%h exp=00000018", imem_raddr); end
        checks++; if (dmem_wen !== 1'b1 || dmem_ren !== 1'b0) begin failures++; $display("FAIL sw_en got=%b%b exp=10", dmem_wen, dmem_ren); end
        checks++; if (dmem_addr !== 32'h100 || dmem_mask !== 4'b1111) begin failures++; $display("FAIL sw_addr_mask got=%h/%b exp=00000100/1111", dmem_addr, dmem_mask); end
        checks++; if (dmem_wdata !== 32'h12345678) begin failures++; $display("FAIL sw_wdata got=%h exp=12345678", dmem_wdata); end
        checks++; if (ret_rd_waddr !== 5'd0) begin failures++; $display("FAIL sw_nowrite got=%0d exp=0", ret_rd_waddr); end
        step();
        drive(32'h002081A3, 32'h0);
        checks++; if (dmem_addr !== 32'h100 || dmem_mask !== 4'b1000) begin failures++; $display("FAIL sb_addr_mask got=%h/%b exp=00000100/1000", dmem_addr, dmem_mask); end
        checks++; if (dmem_wdata[31:24] !== 8'h78 || dmem_wen !== 1'b1) begin failures++; $display("FAIL sb_lane got=%h/%b exp=78/1", dmem_wdata[31:24], dmem_wen); end
        step();
        drive(32'hFF1FF0EF, 32'h0);
        checks++; if (ret_rd_waddr !== 5'd1 || ret_rd_wdata !== 32'h24) begin failures++; $display("FAIL jal_link got=%0d/%h exp=1/00000024", ret_rd_waddr, ret_rd_wdata); end
        checks++; if (ret_next_pc !== 32'h10) begin failures++; $display("FAIL jal_next_pc got=%h exp=00000010", ret_next_pc); end
        step();
    endtask

    task automatic test_loads();
        drive(32'h10000093, 32'h0);
        checks++; if (imem_raddr !== 32'h10) begin failures++; $display("FAIL jal_target_fetch got=%h exp=00000010", imem_raddr); end
        step();
        drive(32'h00308183, 32'h78345678);
        checks++; if (dmem_ren !== 1'b1 || dmem_wen !== 1'b0 || dmem_mask !== 4'b1000) begin failures++; $display("FAIL lb3_mem got=%b%b%b exp=101000", dmem_ren, dmem_wen, dmem_mask); end
        checks++; if (ret_rd_wdata !== 32'h00000078 || ret_rd_waddr !== 5'd3) begin failures++; $display("FAIL lb3_data got=%h/%0d exp=00000078/3", ret_rd_wdata, ret_rd_waddr); end
        step();
        drive(32'h00018233, 32'h0);
        checks++; if (ret_rs1_rdata !== 32'h78 || ret_rd_wdata !== 32'h78) begin failures++; $display("FAIL x3_readback got=%h/%h exp=00000078/00000078", ret_rs1_rdata, ret_rd_wdata); end
        step();
        drive(32'h00108283, 32'h00008000);
        checks++; if (ret_rd_wdata !== 32'hFFFFFF80 || dmem_mask !== 4'b0010) begin failures++; $display("FAIL lb_sign got=%h/%b exp=ffffff80/0010", ret_rd_wdata, dmem_mask); end
        step();
        drive(32'h0010C283, 32'h00008000);
        checks++; if (ret_rd_wdata !== 32'h00000080) begin failures++; $display("FAIL lbu_zero got=%h exp=00000080", ret_rd_wdata); end
        step();
        drive(32'h00209303, 32'h80010000);
        checks++; if (ret_rd_wdata !== 32'hFFFF8001 || dmem_mask !== 4'b1100) begin failures++; $display("FAIL lh_upper got=%h/%b exp=ffff8001/1100", ret_rd_wdata, dmem_mask); end
        step();
    endtask

    task automatic test_alu_ops();
        drive(32'h402083B3, 32'h0);
        checks++; if (ret_rd_wdata !== 32'hEDCBAA88) begin failures++; $display("FAIL sub got=%h exp=edcbaa88", ret_rd_wdata); end
        step();
        drive(32'h4043D413, 32'h0);
        checks++; if (ret_rd_wdata !== 32'hFEDCBAA8) begin failures++; $display("FAIL srai got=%h exp=fedcbaa8", ret_rd_wdata); end
        step();
        drive(32'h0013A4B3, 32'h0);
        checks++; if (ret_rd_wdata !== 32'h1) begin failures++; $display("FAIL slt got=%h exp=00000001", ret_rd_wdata); end
        step();
        drive(32'h0013B533, 32'h0);
        checks++; if (ret_rd_wdata !== 32'h0 || ret_rd_waddr !== 5'd10) begin failures++; $display("FAIL sltu got=%h/%0d exp=00000000/10", ret_rd_wdata, ret_rd_waddr); end
        step();
    endtask

    task automatic test_jalr();
        drive(32'h041085E7, 32'h0);
        checks++; if (ret_pc !== 32'h38 || ret_rd_wdata !== 32'h3C) begin failures++; $display("FAIL jalr_link got=%h/%h exp=00000038/0000003c", ret_pc, ret_rd_wdata); end
        checks++; if (ret_next_pc !== 32'h140 || ret_trap !== 1'b0) begin failures++; $display("FAIL jalr_target got=%h/%b exp=00000140/0", ret_next_pc, ret_trap); end
        step();
    endtask

    task automatic test_branch_target();
        drive(32'h00001163, 32'h0);
        checks++; if (imem_raddr !== 32'h140) begin failures++; $display("FAIL jalr_fetch got=%h exp=00000140", imem_raddr); end
        checks++; if (ret_trap !== 1'b0 || ret_next_pc !== 32'h144) begin failures++; $display("FAIL bne_not_taken got=%b/%h exp=0/00000144", ret_trap, ret_next_pc); end
        step();
        drive(32'h00000163, 32'h0);
        checks++; if (ret_trap !== 1'b1 || ret_valid !== 1'b1) begin failures++; $display("FAIL beq_misaligned_trap got=%b/%b exp=1/1", ret_trap, ret_valid); end
        step();
        drive(32'h00500093, 32'h0);
        checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL after_branch_trap_valid got=%b exp=0", ret_valid); end
        do_reset();
    endtask

    task automatic test_misaligned_load();
        drive(32'h10000093, 32'h0);
        step();
        drive(32'h0020A603, 32'h0);
        checks++; if (ret_trap !== 1'b1 || ret_valid !== 1'b1) begin failures++; $display("FAIL lw_mis_trap got=%b/%b exp=1/1", ret_trap, ret_valid); end
        checks++; if (dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin failures++; $display("FAIL lw_mis_mem got=%b%b exp=00", dmem_ren, dmem_wen); end
        checks++; if (ret_rd_waddr !== 5'd0 || ret_rd_wdata !== 32'h0) begin failures++; $display("FAIL lw_mis_nowrite got=%0d/%h exp=0/0", ret_rd_waddr, ret_rd_wdata); end
        step();
        drive(32'h0020A023, 32'h0);
        checks++; if (ret_valid !== 1'b0 || dmem_wen !== 1'b0 || dmem_ren !== 1'b0) begin failures++; $display("FAIL halted_after_trap got=%b%b%b exp=000", ret_valid, dmem_wen, dmem_ren); end
        do_reset();
    endtask

    task automatic test_illegal();
        drive(32'h00000000, 32'h0);
        checks++; if (ret_trap !== 1'b1 || ret_rd_waddr !== 5'd0) begin failures++; $display("FAIL illegal_zero got=%b/%0d exp=1/0", ret_trap, ret_rd_waddr); end
        step();
        drive(32'h00500093, 32'h0);
        checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL illegal_halt got=%b exp=0", ret_valid); end
        do_reset();
        drive(32'h00000073, 32'h0);
        checks++; if (ret_trap !== 1'b1 || ret_halt !== 1'b0) begin failures++; $display("FAIL ecall_trap got=%b/%b exp=1/0", ret_trap, ret_halt); end
        do_reset();
    endtask

    task automatic test_ebreak_halt();
        drive(32'h00500093, 32'h0);
        step();
        drive(32'h00100073, 32'h0);
        checks++; if (ret_halt !== 1'b1 || ret_trap !== 1'b0 || ret_valid !== 1'b1) begin failures++; $display("FAIL ebreak_retire got=%b%b%b exp=101", ret_halt, ret_trap, ret_valid); end
        checks++; if (ret_rd_waddr !== 5'd0) begin failures++; $display("FAIL ebreak_nowrite got=%0d exp=0", ret_rd_waddr); end
        step();
        for (int k = 0; k < 3; k++) begin
            drive(32'h0020A023, 32'h0);
            checks++; if (ret_valid !== 1'b0 || dmem_wen !== 1'b0 || ret_halt !== 1'b0) begin failures++; $display("FAIL halted_cycle%0d got=%b%b%b exp=000", k, ret_valid, dmem_wen, ret_halt); end
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_raddr !== 32'h0) begin failures++; $display("FAIL halt_reset_pc got=%h exp=00000000", imem_raddr); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h00008233, 32'h0);
        checks++; if (ret_valid !== 1'b1 || ret_pc !== 32'h0) begin failures++; $display("FAIL restart got=%b/%h exp=1/00000000", ret_valid, ret_pc); end
        checks++; if (ret_rs1_rdata !== 32'h0) begin failures++; $display("FAIL x1_cleared got=%h exp=00000000", ret_rs1_rdata); end
        step();
    endtask

    task automatic test_reset_midcycle();
        drive(32'h0020A023, 32'h0);
        checks++; if (dmem_wen !== 1'b1 || imem_raddr !== 32'h4) begin failures++; $display("FAIL midrst_pre got=%b/%h exp=1/00000004", dmem_wen, imem_raddr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dmem_wen !== 1'b0 || ret_valid !== 1'b0) begin failures++; $display("FAIL midrst_gate got=%b%b exp=00", dmem_wen, ret_valid); end
        checks++; if (imem_raddr !== 32'h0) begin failures++; $display("FAIL midrst_pc got=%h exp=00000000", imem_raddr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        imem_rdata = 32'h0;
        dmem_rdata = 32'h0;
        rst_n      = 1'b0;
        test_reset();
        test_first_addi();
        test_setup_regs();
        test_branch_store_jal();
        test_loads();
        test_alu_ops();
        test_jalr();
        test_branch_target();
        test_misaligned_load();
        test_illegal();
        test_ebreak_halt();
        test_reset_midcycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
